// File: rtl/riscv_pkg.sv
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RV32I encodings for the EX/MEM load/store stage:
//                opcode constants, funct3 access sizes, the LSU state
//                enum and the alignment rule used when capturing an access.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    // Major opcode field inst[6:2]
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    // Access size, funct3[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Canonical bubble: addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Bytes are always aligned; halves need a[0]=0; words need a[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_lsu_if.sv
// ============================================================================
//  Module      : ex_mem_lsu_if
//  Description : Data-memory request/grant/response bundle.
//                master : LSU side (drives req/we/addr/wdata/be)
//                slave  : memory side (drives gnt/rvalid/rdata)
//  Ports       : req, we, addr[31:0], wdata[31:0], be[3:0],
//                gnt, rvalid, rdata[31:0]
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_mem_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
//  Module      : lsu_align
//  Description : Purely combinational byte-lane logic. Builds store byte
//                enables and lane-replicated write data, and extracts and
//                sign/zero-extends load data from the returned word.
//  Ports       : funct3_i[2:0], addr_lo_i[1:0], rs2_i[31:0], rdata_i[31:0]
//                -> be_o[3:0], wdata_o[31:0], ld_data_o[31:0]
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import riscv_pkg::*;
(
    input  wire logic [2:0]  funct3_i,
    input  wire logic [1:0]  addr_lo_i,
    input  wire logic [31:0] rs2_i,
    input  wire logic [31:0] rdata_i,
    output logic      [3:0]  be_o,
    output logic      [31:0] wdata_o,
    output logic      [31:0] ld_data_o
);

    logic [31:0] w_shifted;
    logic        w_sext;

    // Bring the addressed byte/half down to bit 0 before extending.
    assign w_shifted = rdata_i >> {addr_lo_i, 3'b000};
    assign w_sext    = ~funct3_i[2];

    always_comb begin
        be_o      = 4'h0;
        wdata_o   = 32'h0;
        ld_data_o = 32'h0;
        case (funct3_i[1:0])
            SZ_BYTE: begin
                be_o      = 4'b0001 << addr_lo_i;
                wdata_o   = {4{rs2_i[7:0]}};
                ld_data_o = {{24{w_sext & w_shifted[7]}}, w_shifted[7:0]};
            end
            SZ_HALF: begin
                be_o      = 4'b0011 << addr_lo_i;
                wdata_o   = {2{rs2_i[15:0]}};
                ld_data_o = {{16{w_sext & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                be_o      = 4'hF;
                wdata_o   = rs2_i;
                ld_data_o = w_shifted;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ex_mem_lsu.sv
// ============================================================================
//  Module      : ex_mem_lsu
//  Description : EX/MEM pipeline register fused with the load/store unit.
//                Captures the EX result, issues one data-memory transaction
//                per aligned load/store, stalls upstream while it is in
//                flight and presents aligned load data to MEM/WB.
//  Ports       : clk_i, rst_ni (async, active-low)
//                en_i, flush_i, valid_i, pc_i, inst_i, alu_i, rs2_i   (EX in)
//                valid_o, pc_o, inst_o, alu_o, ld_data_o, misalign_o,
//                stall_o                                               (out)
//                dmem : ex_mem_lsu_if.master                     (memory bus)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_lsu
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_ni,
    input  wire logic                  en_i,
    input  wire logic                  flush_i,
    input  wire logic                  valid_i,
    input  wire logic [DATA_WIDTH-1:0] pc_i,
    input  wire logic [DATA_WIDTH-1:0] inst_i,
    input  wire logic [DATA_WIDTH-1:0] alu_i,
    input  wire logic [DATA_WIDTH-1:0] rs2_i,
    output logic                       valid_o,
    output logic      [DATA_WIDTH-1:0] pc_o,
    output logic      [DATA_WIDTH-1:0] inst_o,
    output logic      [DATA_WIDTH-1:0] alu_o,
    output logic      [DATA_WIDTH-1:0] ld_data_o,
    output logic                       misalign_o,
    output logic                       stall_o,
    ex_mem_lsu_if.master               dmem
);

    lsu_state_e            state_q, state_d;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] pc_q, inst_q, alu_q, rs2_q, ld_q, ld_d;

    logic                  w_capture;
    logic                  w_in_real, w_in_mem, w_in_load, w_in_mis;
    lsu_state_e            w_cap_state;
    logic                  w_is_ld, w_is_st, w_req;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata, w_ld_ext;

    // ------------------------------------------------------------------
    // Capture decode: the next state is chosen from the incoming EX
    // instruction so the request goes out the cycle after capture.
    // ------------------------------------------------------------------
    assign stall_o   = (state_q == LSU_REQ) || (state_q == LSU_WAIT);
    assign w_capture = en_i && !stall_o;

    assign w_in_real = valid_i && !flush_i;
    assign w_in_load = w_in_real && (inst_i[6:2] == OP_LOAD);
    assign w_in_mem  = w_in_load || (w_in_real && (inst_i[6:2] == OP_STORE));
    assign w_in_mis  = is_misaligned(inst_i[13:12], alu_i[1:0]);

    always_comb begin
        w_cap_state = LSU_IDLE;
        if (w_in_mem) begin
            w_cap_state = w_in_mis ? LSU_DONE : LSU_REQ;
        end
    end

    // Held-instruction decode
    assign w_is_ld = valid_q && (inst_q[6:2] == OP_LOAD);
    assign w_is_st = valid_q && (inst_q[6:2] == OP_STORE);

    lsu_align u_align (
        .funct3_i  (inst_q[14:12]),
        .addr_lo_i (alu_q[1:0]),
        .rs2_i     (rs2_q),
        .rdata_i   (dmem.rdata),
        .be_o      (w_be),
        .wdata_o   (w_wdata),
        .ld_data_o (w_ld_ext)
    );

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LSU_REQ: begin
                if (dmem.gnt) begin
                    state_d = w_is_st ? LSU_DONE : LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (dmem.rvalid) begin
                    state_d = LSU_DONE;
                end
            end
            default: begin
                if (w_capture) begin
                    state_d = w_cap_state;
                end
            end
        endcase
    end

    // Load data: updated on the response, cleared when a misaligned load
    // is captured, otherwise held.
    always_comb begin
        ld_d = ld_q;
        if ((state_q == LSU_WAIT) && dmem.rvalid) begin
            ld_d = w_ld_ext;
        end else if (w_capture && w_in_load && w_in_mis) begin
            ld_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LSU_IDLE;
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
            alu_q   <= '0;
            rs2_q   <= '0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            if (w_capture) begin
                valid_q <= w_in_real;
                pc_q    <= pc_i;
                inst_q  <= flush_i ? NOP_INST : inst_i;
                alu_q   <= alu_i;
                rs2_q   <= rs2_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Bus fields are gated by req so the bus is quiet outside
    // a transaction; they come from held registers, so they stay stable
    // until the grant.
    // ------------------------------------------------------------------
    assign w_req       = (state_q == LSU_REQ);
    assign dmem.req    = w_req;
    assign dmem.we     = w_req && w_is_st;
    assign dmem.addr   = w_req ? {alu_q[31:2], 2'b00} : 32'h0;
    assign dmem.be     = w_req ? w_be : 4'h0;
    assign dmem.wdata  = (w_req && w_is_st) ? w_wdata : 32'h0;

    assign valid_o     = valid_q;
    assign pc_o        = pc_q;
    assign inst_o      = inst_q;
    assign alu_o       = alu_q;
    assign ld_data_o   = ld_q;
    assign misalign_o  = (w_is_ld || w_is_st) && is_misaligned(inst_q[13:12], alu_q[1:0]);

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_lsu.sv
// ============================================================================
//  Module      : tb_ex_mem_lsu
//  Description : Self-checking bench for ex_mem_lsu: reset state, a table of
//                directed vectors, hand-written reset-during-access
//                sequence, and randomized operations against a behavioural
//                model of the load/store rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en, flush, valid;
    logic [31:0] pc, inst_i, alu_i, rs2_i;
    logic        valid_o, misalign_o, stall_o;
    logic [31:0] pc_o, inst_o, alu_o, ld_data_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] pcv = 32'h0000_1000;
    logic [31:0] exp_ld = 32'h0;

    ex_mem_lsu_if mif();

    ex_mem_lsu #(.DATA_WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .flush_i    (flush),
        .valid_i    (valid),
        .pc_i       (pc),
        .inst_i     (inst_i),
        .alu_i      (alu_i),
        .rs2_i      (rs2_i),
        .valid_o    (valid_o),
        .pc_o       (pc_o),
        .inst_o     (inst_o),
        .alu_o      (alu_o),
        .ld_data_o  (ld_data_o),
        .misalign_o (misalign_o),
        .stall_o    (stall_o),
        .dmem       (mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {17'd0, f3, 5'd0, op};
    endfunction

    // Behavioural model: derived from access size and byte offset arithmetic.
    function automatic void model(input logic [31:0] inst, alu, rs2, rdata,
                                  output bit ismem, output bit isld, output bit mis,
                                  output logic [3:0] be, output logic [31:0] wd,
                                  output logic [31:0] ld);
        int     sz, off;
        longint v;
        isld  = (inst[6:0] == 7'h03);
        ismem = isld || (inst[6:0] == 7'h23);
        sz    = 1 << inst[13:12];
        off   = int'(alu % 4);
        mis   = ismem && ((alu % sz) != 0);
        be    = 4'h0;
        wd    = 32'h0;
        for (int i = 0; i < 4; i++) begin
            be[i]        = (i >= off) && (i < off + sz);
            wd[8*i +: 8] = rs2[8*(i % sz) +: 8];
        end
        v = longint'(rdata >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
        if (!inst[14] && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
        ld = v[31:0];
    endfunction

    // Issue one instruction, act as memory with the given grant/response
    // delays, and return what the stage showed once it stopped stalling.
    task automatic run_op(input logic [31:0] inst, alu, rs2, rdata, input int gd, rd,
                          output int o_stall, output int o_req,
                          output logic [3:0] o_be, output logic [31:0] o_wd,
                          output logic [31:0] o_ld, output logic o_mis);
        logic [31:0] nxt_alu;
        logic        nxt_flush;
        logic        is_st;
        int          waitc, cyc;
        is_st = (inst[6:0] == 7'h23);
        @(negedge clk);
        en = 1'b1; flush = 1'b0; valid = 1'b1; pc = pcv;
        inst_i = inst; alu_i = alu; rs2_i = rs2;
        mif.gnt = 1'b0; mif.rvalid = 1'b0;
        @(posedge clk); #1;
        chk("pc_o", pc_o, pcv);
        chk("inst_o", inst_o, inst);
        pcv += 4;
        o_stall = 0; o_req = 0; o_be = 4'h0; o_wd = 32'h0;
        waitc = 0; cyc = 0;
        nxt_alu = ~alu;
        nxt_flush = 1'($urandom_range(0, 1));
        while (stall_o && cyc < 64) begin
            o_stall++;
            if (mif.req) begin
                o_req++;
                chk("dmem_addr", mif.addr, {alu[31:2], 2'b00});
                chk("dmem_we", {31'd0, mif.we}, {31'd0, is_st});
                if (o_req == 1) begin
                    o_be = mif.be; o_wd = mif.wdata;
                end else if (is_st) begin
                    chk("be_stable", {28'd0, mif.be}, {28'd0, o_be});
                    chk("wdata_stable", mif.wdata, o_wd);
                end
            end
            @(negedge clk);
            // Next instruction waits upstream; it must not be taken while stalled.
            valid = 1'b1; inst_i = mk(7'h13, 3'd0); alu_i = nxt_alu; flush = nxt_flush;
            mif.gnt = 1'b0; mif.rvalid = 1'b0; mif.rdata = $urandom;
            if (mif.req) begin
                if (o_req - 1 == gd) begin
                    mif.gnt = 1'b1;
                    mif.rvalid = 1'($urandom_range(0, 1));
                end
            end else begin
                mif.gnt = 1'($urandom_range(0, 1));
                if (waitc == rd) begin
                    mif.rvalid = 1'b1; mif.rdata = rdata;
                end
                waitc++;
            end
            @(posedge clk); #1;
            cyc++;
            chk("alu_held", alu_o, alu);
        end
        if (cyc >= 64) chk("stall_timeout", {31'd0, stall_o}, 32'd0);
        o_ld = ld_data_o;
        o_mis = misalign_o;
        if (o_stall > 0) begin
            @(negedge clk);
            mif.gnt = 1'b0; mif.rvalid = 1'b0;
            @(posedge clk); #1;
            if (nxt_flush) begin
                chk("flush_valid", {31'd0, valid_o}, 32'd0);
                chk("flush_inst", inst_o, 32'h0000_0013);
            end else begin
                chk("next_capture", alu_o, nxt_alu);
            end
        end
    endtask

    typedef struct {
        logic [31:0] inst, alu, rs2, rdata;
        int          gd, rd;
        int          exp_stall, exp_req;
        logic        exp_mis;
        logic        chk_ld;
        logic [31:0] exp_ld;
        logic        chk_st;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int          st, rq;
        logic [3:0]  be, mbe;
        logic [31:0] wd, ld, mwd, mld, inst, alu, rs2, rdata;
        logic        mis;
        bit          mmem, mld_op, mmis;
        int          gd, rd, es;

        en = 0; flush = 0; valid = 0; pc = 0; inst_i = 0; alu_i = 0; rs2_i = 0;
        mif.gnt = 0; mif.rvalid = 0; mif.rdata = 0;

        //             inst            alu           rs2           rdata        gd rd st rq mis chk_ld ld       chk_st be     wd
        tbl[0]  = '{mk(7'h33,3'd0), 32'h0000_1234, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0, 32'h0,        0, 4'h0, 32'h0};
        tbl[1]  = '{mk(7'h23,3'd2), 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,       2, 0, 3, 3, 0, 0, 32'h0,        1, 4'hF, 32'hDEAD_BEEF};
        tbl[2]  = '{mk(7'h03,3'd0), 32'h0000_0203, 32'h0,        32'h80FF_FF7F, 0, 0, 2, 1, 0, 1, 32'hFFFF_FF80, 0, 4'h0, 32'h0};
        tbl[3]  = '{mk(7'h03,3'd4), 32'h0000_0203, 32'h0,        32'h80FF_FF7F, 0, 0, 2, 1, 0, 1, 32'h0000_0080, 0, 4'h0, 32'h0};
        tbl[4]  = '{mk(7'h03,3'd1), 32'h0000_0201, 32'h0,        32'h0,        0, 0, 0, 0, 1, 1, 32'h0,        0, 4'h0, 32'h0};
        tbl[5]  = '{mk(7'h03,3'd2), 32'h0000_0300, 32'h0,        32'h1234_5678, 0, 2, 4, 1, 0, 1, 32'h1234_5678, 0, 4'h0, 32'h0};
        tbl[6]  = '{mk(7'h23,3'd0), 32'h0000_0102, 32'h0000_00AB, 32'h0,       0, 0, 1, 1, 0, 0, 32'h0,        1, 4'h4, 32'hABAB_ABAB};
        tbl[7]  = '{mk(7'h23,3'd1), 32'h0000_0106, 32'h1234_CDEF, 32'h0,       1, 0, 2, 2, 0, 0, 32'h0,        1, 4'hC, 32'hCDEF_CDEF};
        tbl[8]  = '{mk(7'h03,3'd5), 32'h0000_0202, 32'h0,        32'h8001_7FFF, 1, 0, 3, 2, 0, 1, 32'h0000_8001, 0, 4'h0, 32'h0};
        tbl[9]  = '{mk(7'h03,3'd1), 32'h0000_0202, 32'h0,        32'h8001_7FFF, 0, 1, 3, 1, 0, 1, 32'hFFFF_8001, 0, 4'h0, 32'h0};
        tbl[10] = '{mk(7'h23,3'd2), 32'h0000_0102, 32'h1111_1111, 32'h0,       0, 0, 0, 0, 1, 0, 32'h0,        0, 4'h0, 32'h0};
        tbl[11] = '{mk(7'h03,3'd4), 32'h0000_0201, 32'h0,        32'h1122_3344, 0, 0, 2, 1, 0, 1, 32'h0000_0033, 0, 4'h0, 32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", {28'd0, valid_o, misalign_o, stall_o, mif.req}, 32'd0);
        chk("reset_we_be", {27'd0, mif.we, mif.be}, 32'd0);
        chk("reset_pc_inst", pc_o | inst_o, 32'd0);
        chk("reset_alu_ld", alu_o | ld_data_o, 32'd0);
        chk("reset_bus", mif.addr | mif.wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].inst, tbl[i].alu, tbl[i].rs2, tbl[i].rdata, tbl[i].gd, tbl[i].rd,
                   st, rq, be, wd, ld, mis);
            chk($sformatf("v%0d_stall", i), st, tbl[i].exp_stall);
            chk($sformatf("v%0d_req", i), rq, tbl[i].exp_req);
            chk($sformatf("v%0d_mis", i), {31'd0, mis}, {31'd0, tbl[i].exp_mis});
            if (tbl[i].chk_ld) chk($sformatf("v%0d_ld", i), ld, tbl[i].exp_ld);
            if (tbl[i].chk_st) begin
                chk($sformatf("v%0d_be", i), {28'd0, be}, {28'd0, tbl[i].exp_be});
                chk($sformatf("v%0d_wd", i), wd, tbl[i].exp_wd);
            end
        end

        // Reset asserted while a load waits for its data
        @(negedge clk);
        en = 1'b1; flush = 1'b0; valid = 1'b1; inst_i = mk(7'h03, 3'd2); alu_i = 32'h0000_0400;
        @(posedge clk); #1;
        chk("rst_seq_req", {31'd0, mif.req}, 32'd1);
        @(negedge clk);
        mif.gnt = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        chk("rst_seq_wait_stall", {30'd0, stall_o, mif.req}, 32'd2);
        @(negedge clk);
        mif.gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_drop", {29'd0, stall_o, mif.req, valid_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; mif.rvalid = 1'b1; mif.rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk("late_rvalid_ld", ld_data_o, 32'd0);
        chk("late_rvalid_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        mif.rvalid = 1'b0;
        exp_ld = 32'h0;

        // Randomized operations against the model
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 2))
                0: begin
                    logic [2:0] lf3 [5];
                    lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                    inst = mk(7'h03, lf3[$urandom_range(0, 4)]);
                end
                1: inst = mk(7'h23, 3'($urandom_range(0, 2)));
                default: inst = mk(7'h33, 3'($urandom_range(0, 7)));
            endcase
            alu = $urandom; rs2 = $urandom; rdata = $urandom;
            gd = $urandom_range(0, 3); rd = $urandom_range(0, 3);
            model(inst, alu, rs2, rdata, mmem, mld_op, mmis, mbe, mwd, mld);
            if (mld_op) exp_ld = mmis ? 32'h0 : mld;
            es = (!mmem || mmis) ? 0 : (mld_op ? gd + rd + 2 : gd + 1);
            run_op(inst, alu, rs2, rdata, gd, rd, st, rq, be, wd, ld, mis);
            chk("rnd_stall", st, es);
            chk("rnd_req", rq, (!mmem || mmis) ? 0 : gd + 1);
            chk("rnd_mis", {31'd0, mis}, {31'd0, mmis});
            chk("rnd_ld", ld, exp_ld);
            if (mmem && !mld_op && !mmis) begin
                chk("rnd_be", {28'd0, be}, {28'd0, mbe});
                chk("rnd_wd", wd, mwd);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
